// File: rtl/mic_pdm_capture.sv
// ============================================================================
// Module   : mic_pdm_capture
// Summary  : PDM microphone clocking, ones-count decimation to PCM samples,
//            and a hysteresis loudness detector that emits a one-cycle flap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mic_pdm_capture #(
  parameter int MIC_CLK_DIV = 50,
  parameter int WINDOW      = 128,
  parameter int SAMPLE_W    = 8,
  parameter int THRESH_HI   = 40,
  parameter int THRESH_LO   = 20,
  parameter int HOLDOFF     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                micData,
  output logic                micClk,
  output logic                chSel,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic [SAMPLE_W-2:0] amplitude,
  output logic                loud,
  output logic                flap
);

  localparam int c_DIV_W  = $clog2(MIC_CLK_DIV);
  localparam int c_BIT_W  = $clog2(WINDOW);
  localparam int c_HOLD_W = $clog2(HOLDOFF + 1);

  localparam logic [c_DIV_W-1:0]  c_DIV_TC    = c_DIV_W'(MIC_CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WINDOW - 1);
  localparam logic [SAMPLE_W-1:0] c_HALF      = SAMPLE_W'(WINDOW / 2);
  localparam logic [SAMPLE_W-1:0] c_THRESH_HI = SAMPLE_W'(THRESH_HI);
  localparam logic [SAMPLE_W-1:0] c_THRESH_LO = SAMPLE_W'(THRESH_LO);
  localparam logic [c_HOLD_W-1:0] c_HOLDOFF   = c_HOLD_W'(HOLDOFF);

  localparam logic [0:0] c_QUIET = 1'b0;
  localparam logic [0:0] c_LOUD  = 1'b1;

  logic [c_DIV_W-1:0]  r_div_cnt;
  logic                r_mic_clk;
  logic                r_sync1;
  logic                r_sync2;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [SAMPLE_W-1:0] r_ones;
  logic [SAMPLE_W-1:0] r_sample;
  logic [SAMPLE_W-2:0] r_amplitude;
  logic                r_sample_valid;
  logic [0:0]          r_state;
  logic [c_HOLD_W-1:0] r_holdoff;
  logic                r_flap;

  logic                w_div_tc;
  logic                w_capture;
  logic                w_last_bit;
  logic [SAMPLE_W-1:0] w_final;
  logic [SAMPLE_W-2:0] w_amp;

  assign w_div_tc   = (r_div_cnt == c_DIV_TC);
  // Sample in the last clk cycle of the high half, just before micClk falls.
  assign w_capture  = enable && r_mic_clk && w_div_tc;
  assign w_last_bit = (r_bit_cnt == c_BIT_LAST);
  assign w_final    = r_ones + {{(SAMPLE_W-1){1'b0}}, r_sync2};
  assign w_amp      = (w_final >= c_HALF) ? (SAMPLE_W-1)'(w_final - c_HALF)
                                          : (SAMPLE_W-1)'(c_HALF - w_final);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_mic_clk <= 1'b0;
    end else if (!enable) begin
      r_div_cnt <= '0;
      r_mic_clk <= 1'b0;
    end else if (w_div_tc) begin
      r_div_cnt <= '0;
      r_mic_clk <= ~r_mic_clk;
    end else begin
      r_div_cnt <= r_div_cnt + c_DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= micData;
      r_sync2 <= r_sync1;
    end
  end

  // The window's last bit is folded into w_final so nothing is lost at the restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_ones    <= '0;
    end else if (!enable) begin
      r_bit_cnt <= '0;
      r_ones    <= '0;
    end else if (w_capture) begin
      if (w_last_bit) begin
        r_bit_cnt <= '0;
        r_ones    <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
        r_ones    <= w_final;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample       <= '0;
      r_amplitude    <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= w_capture && w_last_bit;
      if (w_capture && w_last_bit) begin
        r_sample    <= w_final;
        r_amplitude <= w_amp;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_QUIET;
      r_holdoff <= '0;
      r_flap    <= 1'b0;
    end else begin
      r_flap <= 1'b0;
      if (r_sample_valid) begin
        case (r_state)
          c_QUIET: begin
            if ({1'b0, r_amplitude} >= c_THRESH_HI) begin
              r_state   <= c_LOUD;
              r_holdoff <= c_HOLDOFF;
              r_flap    <= 1'b1;
            end
          end
          c_LOUD: begin
            if (r_holdoff != '0) begin
              r_holdoff <= r_holdoff - c_HOLD_W'(1);
            end else if ({1'b0, r_amplitude} < c_THRESH_LO) begin
              r_state <= c_QUIET;
            end
          end
          default: r_state <= c_QUIET;
        endcase
      end
    end
  end

  assign micClk       = r_mic_clk;
  assign chSel        = 1'b0;
  assign sample_out   = r_sample;
  assign amplitude    = r_amplitude;
  assign sample_valid = r_sample_valid;
  assign loud         = (r_state == c_LOUD);
  assign flap         = r_flap;

endmodule

`default_nettype wire

// File: tb/tb_mic_pdm_capture.sv
// ============================================================================
// Module   : tb_mic_pdm_capture
// Summary  : Self-checking bench for mic_pdm_capture against a window model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mic_pdm_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic en_d = 0, en_h = 0, en_y = 0;
  logic mic_d = 0, mic_h = 0, mic_y = 0;

  logic d_mclk, d_ch, d_valid, d_loud, d_flap;
  logic [7:0] d_sample;
  logic [6:0] d_amp;
  logic h_mclk, h_ch, h_valid, h_loud, h_flap;
  logic [4:0] h_sample;
  logic [3:0] h_amp;
  logic y_mclk, y_ch, y_valid, y_loud, y_flap;
  logic [3:0] y_sample;
  logic [2:0] y_amp;

  mic_pdm_capture u_def (
    .clk(clk), .reset(rst), .enable(en_d), .micData(mic_d), .micClk(d_mclk),
    .chSel(d_ch), .sample_out(d_sample), .sample_valid(d_valid),
    .amplitude(d_amp), .loud(d_loud), .flap(d_flap));

  mic_pdm_capture #(.MIC_CLK_DIV(2), .WINDOW(16), .SAMPLE_W(5), .THRESH_HI(5),
                    .THRESH_LO(3), .HOLDOFF(4)) u_hld (
    .clk(clk), .reset(rst), .enable(en_h), .micData(mic_h), .micClk(h_mclk),
    .chSel(h_ch), .sample_out(h_sample), .sample_valid(h_valid),
    .amplitude(h_amp), .loud(h_loud), .flap(h_flap));

  mic_pdm_capture #(.MIC_CLK_DIV(2), .WINDOW(8), .SAMPLE_W(4), .THRESH_HI(3),
                    .THRESH_LO(2), .HOLDOFF(1)) u_hys (
    .clk(clk), .reset(rst), .enable(en_y), .micData(mic_y), .micClk(y_mclk),
    .chSel(y_ch), .sample_out(y_sample), .sample_valid(y_valid),
    .amplitude(y_amp), .loud(y_loud), .flap(y_flap));

  int W_[3]  = '{128, 16, 8};
  int HI_[3] = '{40, 5, 3};
  int LO_[3] = '{20, 3, 2};
  int HO_[3] = '{4, 4, 1};

  int checks = 0;
  int failures = 0;
  int act = 0;
  int en_cyc = 0;

  // Reference state: detector per instance plus last published sample.
  int ml[3] = '{0, 0, 0};
  int mh[3] = '{0, 0, 0};
  int lc[3] = '{0, 0, 0};
  int la[3] = '{0, 0, 0};
  int exp_flaps[3] = '{0, 0, 0};
  int e_cnt[$], e_amp[$], e_loud[$], e_flap[$];

  int m_cnt[$], m_amp[$], m_loud[$], m_flap[$], m_cyc[$];
  int ftot[3] = '{0, 0, 0};
  int ch_bad = 0;
  logic mv_prev = 1'b0;
  logic [127:0] pat_q[$];

  logic a_valid, a_loud, a_flap;
  logic [7:0] a_cnt;
  logic [6:0] a_amp;
  always_comb begin
    a_valid = d_valid; a_loud = d_loud; a_flap = d_flap; a_cnt = d_sample; a_amp = d_amp;
    if (act == 1) begin
      a_valid = h_valid; a_loud = h_loud; a_flap = h_flap;
      a_cnt = {3'b000, h_sample}; a_amp = {3'b000, h_amp};
    end else if (act == 2) begin
      a_valid = y_valid; a_loud = y_loud; a_flap = y_flap;
      a_cnt = {4'b0000, y_sample}; a_amp = {4'b0000, y_amp};
    end
  end

  always @(negedge clk) begin
    if (mv_prev) begin
      m_loud.push_back(int'(a_loud));
      m_flap.push_back(int'(a_flap));
    end
    if (a_valid) begin
      m_cnt.push_back(int'(a_cnt));
      m_amp.push_back(int'(a_amp));
      m_cyc.push_back(cyc);
    end
    mv_prev <= a_valid;
    if (d_flap) ftot[0] <= ftot[0] + 1;
    if (h_flap) ftot[1] <= ftot[1] + 1;
    if (y_flap) ftot[2] <= ftot[2] + 1;
    if (d_ch || h_ch || y_ch) ch_bad <= ch_bad + 1;
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int expv, input int tol);
    checks++;
    assert (obs >= expv - tol && obs <= expv + tol) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, expv, tol);
    end
  endtask

  task automatic timeout_abort(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bounded wait expired");
  endtask

  function automatic logic get_mclk(input int s);
    return (s == 0) ? d_mclk : (s == 1) ? h_mclk : y_mclk;
  endfunction

  task automatic set_mic(input int s, input logic b);
    if (s == 0) mic_d = b; else if (s == 1) mic_h = b; else mic_y = b;
  endtask

  task automatic set_en(input int s, input logic b);
    if (s == 0) en_d = b; else if (s == 1) en_h = b; else en_y = b;
  endtask

  task automatic wait_fall(input int s);
    logic prev, cur;
    int n;
    prev = get_mclk(s);
    n = 0;
    forever begin
      @(negedge clk);
      cur = get_mclk(s);
      if (prev && !cur) break;
      prev = cur;
      n++;
      if (n > 1000) timeout_abort("mclk_fall_wait");
    end
  endtask

  task automatic wait_level(input int s, input logic lvl, output int t);
    int n;
    n = 0;
    while (get_mclk(s) !== lvl) begin
      @(negedge clk);
      n++;
      if (n > 1000) timeout_abort("mclk_level_wait");
    end
    t = cyc;
  endtask

  // Window-level reference: count of ones -> amplitude -> detector decision.
  task automatic model_window(input int s, input int c);
    int a, f;
    a = (c >= W_[s] / 2) ? c - W_[s] / 2 : W_[s] / 2 - c;
    f = 0;
    if (ml[s] == 0) begin
      if (a >= HI_[s]) begin ml[s] = 1; mh[s] = HO_[s]; f = 1; end
    end else if (mh[s] > 0) begin
      mh[s]--;
    end else if (a < LO_[s]) begin
      ml[s] = 0;
    end
    lc[s] = c; la[s] = a;
    exp_flaps[s] += f;
    e_cnt.push_back(c); e_amp.push_back(a); e_loud.push_back(ml[s]); e_flap.push_back(f);
  endtask

  function automatic logic [127:0] rand_pat(input int s);
    logic [127:0] p;
    int dens;
    p = '0;
    dens = $urandom_range(0, 16);
    for (int k = 0; k < W_[s]; k++) p[k] = ($urandom_range(0, 15) < dens);
    return p;
  endfunction

  task automatic run_seq(input int s);
    m_cyc.delete();
    for (int w = 0; w < pat_q.size(); w++) begin
      model_window(s, $countones(pat_q[w]));
      for (int k = 0; k < W_[s]; k++) begin
        if (w == 0 && k == 0) begin
          set_mic(s, pat_q[w][k]);
          set_en(s, 1'b1);
          en_cyc = cyc;
        end else begin
          wait_fall(s);
          set_mic(s, pat_q[w][k]);
        end
      end
    end
    wait_fall(s);
    repeat (3) @(negedge clk);
    set_en(s, 1'b0);
    repeat (4) @(negedge clk);
    pat_q.delete();
  endtask

  task automatic check_results(input string tag);
    int n;
    chk({tag, ".num_valid"}, m_cnt.size(), e_cnt.size());
    chk({tag, ".num_after"}, m_loud.size(), e_loud.size());
    n = (m_cnt.size() < e_cnt.size()) ? m_cnt.size() : e_cnt.size();
    if (m_loud.size() < n) n = m_loud.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].sample_out", tag, i), m_cnt[i], e_cnt[i]);
      chk($sformatf("%s[%0d].amplitude", tag, i), m_amp[i], e_amp[i]);
      chk($sformatf("%s[%0d].loud", tag, i), m_loud[i], e_loud[i]);
      chk($sformatf("%s[%0d].flap", tag, i), m_flap[i], e_flap[i]);
    end
    m_cnt.delete(); m_amp.delete(); m_loud.delete(); m_flap.delete();
    e_cnt.delete(); e_amp.delete(); e_loud.delete(); e_flap.delete();
  endtask

  initial begin
    int t_rel, t1, t2, t3, n, highs;
    act = 0;
    repeat (3) @(negedge clk);
    chk("rst.sample_out", int'(d_sample), 0);
    chk("rst.amplitude", int'(d_amp), 0);
    chk("rst.sample_valid", int'(d_valid), 0);
    chk("rst.loud", int'(d_loud), 0);
    chk("rst.flap", int'(d_flap), 0);
    chk("rst.micClk", int'(d_mclk), 0);
    chk("rst.chSel", int'(d_ch), 0);

    // Defaults: constant-ones stream from reset release, clock timing, first flap.
    mic_d = 1'b1;
    en_d = 1'b1;
    rst = 1'b0;
    t_rel = cyc;
    wait_level(0, 1'b1, t1);
    wait_level(0, 1'b0, t2);
    wait_level(0, 1'b1, t3);
    chk("clk.first_rise", t1 - t_rel, 50);
    chk("clk.high_time", t2 - t1, 50);
    chk("clk.period", t3 - t1, 100);
    n = 0;
    while (m_cnt.size() == 0) begin
      @(negedge clk);
      n++;
      if (n > 13100) timeout_abort("first_valid_wait");
    end
    chk_near("clk.first_valid_latency", m_cyc[0] - t_rel, 12800, 3);
    model_window(0, 128);
    repeat (3) @(negedge clk);
    check_results("d_const");

    // Asynchronous reset while LOUD.
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_loud.loud", int'(d_loud), 0);
    chk("rst_loud.flap", int'(d_flap), 0);
    chk("rst_loud.sample_out", int'(d_sample), 0);
    chk("rst_loud.amplitude", int'(d_amp), 0);
    chk("rst_loud.micClk", int'(d_mclk), 0);
    for (int i = 0; i < 3; i++) begin ml[i] = 0; mh[i] = 0; lc[i] = 0; la[i] = 0; end
    en_d = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Defaults: alternating 1,0 stream is perfectly quiet.
    pat_q.push_back({64{2'b01}});
    run_seq(0);
    check_results("d_alt");
    chk("d.flap_total", ftot[0], exp_flaps[0]);

    // Holdoff instance: loud window, five quiet windows, then random windows.
    act = 1;
    pat_q.push_back(128'hFFFF);
    repeat (5) pat_q.push_back(128'h5555);
    repeat (12) pat_q.push_back(rand_pat(1));
    run_seq(1);
    check_results("h_seq");

    // Drop enable mid-window: clock stops, nothing published, outputs hold.
    set_mic(1, 1'b1);
    en_h = 1'b1;
    for (int k = 1; k < 8; k++) begin
      wait_fall(1);
      mic_h = $urandom_range(0, 1);
    end
    @(negedge clk);
    en_h = 1'b0;
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (h_mclk) highs++;
    end
    chk("en_off.micClk_high_cycles", highs, 0);
    chk("en_off.valid_count", m_cnt.size(), 0);
    chk("en_off.sample_out_hold", int'(h_sample), lc[1]);
    chk("en_off.amplitude_hold", int'(h_amp), la[1]);
    chk("en_off.loud_hold", int'(h_loud), ml[1]);

    // Re-enable: a fresh full window precedes the next strobe.
    pat_q.push_back(rand_pat(1));
    run_seq(1);
    if (m_cyc.size() > 0) chk_near("reen.latency", m_cyc[0] - en_cyc, 64, 3);
    else chk("reen.valid_seen", m_cyc.size(), 1);
    check_results("h_reen");
    chk("h.flap_total", ftot[1], exp_flaps[1]);

    // Hysteresis instance: counts 8, 6, 6, 5.
    act = 2;
    pat_q.push_back(128'hFF);
    pat_q.push_back(128'h3F);
    pat_q.push_back(128'h3F);
    pat_q.push_back(128'h1F);
    run_seq(2);
    check_results("y_hys");
    chk("y.flap_total", ftot[2], exp_flaps[2]);
    chk("chSel.nonzero_cycles", ch_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
